// File: rtl/sub_8bit_serial_if.sv
// sub_8bit_serial_if
//   Handshake and data bundle for sub_8bit_serial.
//   Operand side : in_valid, in_ready, a[7:0], b[7:0], bin
//   Result side  : out_valid, out_ready, diff[7:0], bout, ovf (ovf only with SUB_OVF_EN)
//   Modports     : master = producer of operands / consumer of results (testbench or upstream)
//                  slave  = the subtractor itself
//   Configuration macro: SUB_OVF_EN adds the ovf signal.
interface sub_8bit_serial_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
`ifdef SUB_OVF_EN
  logic       ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
`endif
endinterface

// File: rtl/sub_8bit_serial.sv
// sub_8bit_serial
//   Multi-cycle 8-bit subtractor: diff = (a - b - bin) mod 256, bout = borrow-out.
//   One shared 4-bit ripple-borrow slice is used twice: low nibble in LOW,
//   high nibble in HIGH. The result is held in DONE until out_ready.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset
//     bus  - sub_8bit_serial_if.slave (in_valid/in_ready/a/b/bin,
//            out_valid/out_ready/diff/bout[/ovf])
//   Configuration macro: SUB_OVF_EN - adds registered signed-overflow flag ovf.
module sub_8bit_serial (
  input  logic               clk,
  input  logic               rst,
  sub_8bit_serial_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t     state_reg;
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic       bin_reg;
  logic       br_reg;     // borrow from low nibble into high nibble
  logic [7:0] diff_reg;
  logic       bout_reg;
`ifdef SUB_OVF_EN
  logic       ovf_reg;
`endif

  // Shared slice operands: high nibble only while in HIGH, otherwise low nibble.
  logic [3:0] sl_a;
  logic [3:0] sl_b;
  logic [3:0] sl_d;
  logic [4:0] sl_brw;     // sl_brw[i] = borrow into bit i, sl_brw[4] = slice borrow-out

  assign sl_a      = (state_reg == HIGH) ? a_reg[7:4] : a_reg[3:0];
  assign sl_b      = (state_reg == HIGH) ? b_reg[7:4] : b_reg[3:0];
  assign sl_brw[0] = (state_reg == HIGH) ? br_reg     : bin_reg;

  // Ripple-borrow full subtractor chain.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      assign sl_d[gi]     = sl_a[gi] ^ sl_b[gi] ^ sl_brw[gi];
      assign sl_brw[gi+1] = (~sl_a[gi] & sl_b[gi]) |
                            (~(sl_a[gi] ^ sl_b[gi]) & sl_brw[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= 8'h00;
      b_reg     <= 8'h00;
      bin_reg   <= 1'b0;
      br_reg    <= 1'b0;
      diff_reg  <= 8'h00;
      bout_reg  <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          // in_ready is high whenever IDLE and not in reset
          if (bus.in_valid) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            bin_reg   <= bus.bin;
            state_reg <= LOW;
          end
        end
        LOW: begin
          diff_reg[3:0] <= sl_d;
          br_reg        <= sl_brw[4];
          state_reg     <= HIGH;
        end
        HIGH: begin
          diff_reg[7:4] <= sl_d;
          bout_reg      <= sl_brw[4];
`ifdef SUB_OVF_EN
          // Signed overflow: borrow into bit 7 differs from borrow out of bit 7.
          ovf_reg       <= sl_brw[3] ^ sl_brw[4];
`endif
          state_reg     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // in_ready comes from registered state, so an accept can never coincide
  // with an output transfer; it is also forced low during reset.
  assign bus.in_ready  = (state_reg == IDLE) && !rst;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.diff      = diff_reg;
  assign bus.bout      = bout_reg;
`ifdef SUB_OVF_EN
  assign bus.ovf       = ovf_reg;
`endif

endmodule
